regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 16-entry register file between two writeback requesters: req0 (ALU writeback) and req1 (load/memory writeback).
- Uses round-robin arbitration with a valid/ready handshake.
- Contains a clear sequencer that writes CLEAR_VALUE to R0..R15 on request.
- Outputs connect directly to the register file's write_enable, inp_write_address0 and inp_write_data.

Parameters:
- W, 16, data width; must equal the register file's W.
- CLEAR_VALUE, 0, W-bit value written to every register during a clear sweep.

Ports:
- clk  in  1  system clock, rising edge.
- reset_asynchronous  in  1  asynchronous, active-high reset.
- clear_start  in  1  single-cycle pulse; requests a 16-cycle clear sweep.
- req0_valid  in  1  requester 0 has a write pending.
- req0_address  in  4  requester 0 destination register.
- req0_data  in  W  requester 0 write data.
- req0_ready  out  1  requester 0 write accepted this cycle (combinational).
- req1_valid  in  1  requester 1 has a write pending.
- req1_address  in  4  requester 1 destination register.
- req1_data  in  W  requester 1 write data.
- req1_ready  out  1  requester 1 write accepted this cycle (combinational).
- rf_write_enable  out  1  register file write strobe (registered).
- rf_write_address  out  4  register file write address (registered).
- rf_write_data  out  W  register file write data (registered).
- rf_write_source  out  1  0 = req0, 1 = req1 for the current rf write; 0 during clear (registered).
- busy  out  1  high while the clear sweep runs (registered).

Behaviour:
- Reset (asynchronous, active-high):
  - state = ARB, priority pointer = 0, clear counter = 0.
  - rf_write_enable = 0, rf_write_address = 0, rf_write_data = 0, rf_write_source = 0, busy = 0.
  - Ready outputs are 0 while reset is asserted.
- States:
  - ARB: normal arbitration.
  - CLEAR: sweep in progress.
- ARB grant logic (combinational), with ptr = priority pointer:
  - req0_ready = state==ARB & !clear_start & req0_valid & (!req1_valid | ptr==0).
  - req1_ready = state==ARB & !clear_start & req1_valid & (!req0_valid | ptr==1).
  - At most one ready is high per cycle.
- Transfer: occurs when valid & ready.
  - In the following cycle: rf_write_enable = 1, with address/data/source captured from the winner.
  - Latency is exactly 1 cycle from handshake to write strobe.
  - With no transfer, rf_write_enable = 0 next cycle; address/data hold their last values.
- Priority pointer: after a grant to requester k, ptr = !k. It is unchanged when there is no grant.
  - A lone valid requester is granted every cycle regardless of ptr.
- Requester contract: a requester keeps valid, address and data stable until ready. The arbiter does not buffer unaccepted requests.
- Same address from both requesters in one cycle: only the winner is written that cycle. The loser is written on a later grant, so the final value is the loser's data. No merging.
- Sustained throughput: one write per cycle. With both requesters valid continuously, grants alternate 0,1,0,1…
- clear_start handling:
  - In ARB: blocks grants that cycle; next state = CLEAR, counter = 0, busy = 1 next cycle.
  - Any write accepted in the previous cycle still issues in the clear_start cycle, so there is no collision.
- CLEAR: for counter 0..15, each cycle drives rf_write_enable = 1, rf_write_address = counter, rf_write_data = CLEAR_VALUE, rf_write_source = 0.
  - Both readies are 0.
  - After address 15 is written: return to ARB, busy = 0 in the same cycle the address-15 write is presented + 1. The sweep is exactly 16 strobe cycles.
  - clear_start during CLEAR is ignored (no restart).
  - The ptr value is preserved across the sweep.
- Reset mid-sweep: returns immediately to ARB with no further writes. Partially cleared registers are left as written.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds outputs grant_count0 and grant_count1 (16 bits each).
  - Each counts accepted transfers of its requester and saturates at 16'hFFFF.
  - Clear writes are not counted.
  - Cleared only by reset_asynchronous.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single requester: req0_valid=1, addr=3, data=16'h00A5 for one cycle → req0_ready=1 that cycle; next cycle rf_write_enable=1, addr=3, data=16'h00A5, source=0.
- Contention: both valid for 4 cycles after reset (ptr=0), distinct data → grants 0,1,0,1; rf strobes on cycles 2–5 with matching addr/data/source.
- Same address: req0 (addr 7, 16'h1111) and req1 (addr 7, 16'h2222) held until accepted, ptr=0 → write 16'h1111 then 16'h2222 on consecutive cycles.
- Clear sweep: pulse clear_start while req1_valid=1 → no ready for 17 cycles; 16 strobes at addresses 0..15 with data 0; busy high throughout; req1 granted on the first cycle back in ARB.
- Reset mid-sweep: assert reset_asynchronous at counter=5 → outputs zero immediately, state ARB; no writes to addresses 6..15.
- ARB_STATS_EN: 70000 lone req0 grants → grant_count0=16'hFFFF (saturated), grant_count1=0; counts unchanged after a clear sweep.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load writeback, with a 16-entry clear sweep.
// Optional grant statistics counters are compiled in when ARB_STATS_EN is defined.
//
// state | meaning
// ARB   | normal round-robin arbitration between req0 and req1
// CLEAR | sweep writing CLEAR_VALUE to R0..R15, one register per cycle
module regfile_write_arbiter #(
    parameter int             W           = 16,
    parameter logic [W-1:0]   CLEAR_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_asynchronous,
    input  logic             clear_start,
    input  logic             req0_valid,
    input  logic [3:0]       req0_address,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_address,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic             rf_write_enable,
    output logic [3:0]       rf_write_address,
    output logic [W-1:0]     rf_write_data,
    output logic             rf_write_source,
    output logic             busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]      grant_count0,
    output logic [15:0]      grant_count1
`endif
);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t       state, state_next;
    logic         ptr, ptr_next;
    logic [3:0]   cnt, cnt_next;
    logic         we_next;
    logic [3:0]   addr_next;
    logic [W-1:0] data_next;
    logic         src_next;
    logic         busy_next;
    logic         grant_ok;

    assign grant_ok   = (state == ARB) && !clear_start && !reset_asynchronous;
    assign req0_ready = grant_ok && req0_valid && (!req1_valid || !ptr);
    assign req1_ready = grant_ok && req1_valid && (!req0_valid || ptr);

    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            state            <= ARB;
            ptr              <= 1'b0;
            cnt              <= 4'd0;
            rf_write_enable  <= 1'b0;
            rf_write_address <= 4'd0;
            rf_write_data    <= '0;
            rf_write_source  <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_next;
            ptr              <= ptr_next;
            cnt              <= cnt_next;
            rf_write_enable  <= we_next;
            rf_write_address <= addr_next;
            rf_write_data    <= data_next;
            rf_write_source  <= src_next;
            busy             <= busy_next;
        end
    end

    // The first clear strobe is registered on the clear_start edge so the
    // sweep occupies exactly the 16 cycles that busy is high.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        cnt_next   = cnt;
        we_next    = 1'b0;
        addr_next  = rf_write_address;
        data_next  = rf_write_data;
        src_next   = rf_write_source;
        busy_next  = busy;
        case (state)
            ARB: begin
                if (clear_start) begin
                    state_next = CLEAR;
                    cnt_next   = 4'd0;
                    we_next    = 1'b1;
                    addr_next  = 4'd0;
                    data_next  = CLEAR_VALUE;
                    src_next   = 1'b0;
                    busy_next  = 1'b1;
                end else if (req0_ready) begin
                    ptr_next  = 1'b1;
                    we_next   = 1'b1;
                    addr_next = req0_address;
                    data_next = req0_data;
                    src_next  = 1'b0;
                end else if (req1_ready) begin
                    ptr_next  = 1'b0;
                    we_next   = 1'b1;
                    addr_next = req1_address;
                    data_next = req1_data;
                    src_next  = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt == 4'd15) begin
                    state_next = ARB;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next  = cnt + 4'd1;
                    we_next   = 1'b1;
                    addr_next = cnt + 4'd1;
                    data_next = CLEAR_VALUE;
                    src_next  = 1'b0;
                end
            end
            default: begin
                state_next = ARB;
                busy_next  = 1'b0;
            end
        endcase
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clk or posedge reset_asynchronous) begin
        if (reset_asynchronous) begin
            grant_count0 <= 16'd0;
            grant_count1 <= 16'd0;
        end else begin
            if (req0_ready && grant_count0 != 16'hFFFF) grant_count0 <= grant_count0 + 16'd1;
            if (req1_ready && grant_count1 != 16'hFFFF) grant_count1 <= grant_count1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed vector table, clear/reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_asynchronous;
    logic          clear_start;
    logic          req0_valid, req1_valid;
    logic [3:0]    req0_address, req1_address;
    logic [W-1:0]  req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          rf_write_enable;
    logic [3:0]    rf_write_address;
    logic [W-1:0]  rf_write_data;
    logic          rf_write_source;
    logic          busy;
`ifdef ARB_STATS_EN
    logic [15:0]   grant_count0, grant_count1;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.W(W), .CLEAR_VALUE(16'h0000)) dut (
        .clk(clk), .reset_asynchronous(reset_asynchronous), .clear_start(clear_start),
        .req0_valid(req0_valid), .req0_address(req0_address), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_address(req1_address), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
        .rf_write_data(rf_write_data), .rf_write_source(rf_write_source), .busy(busy)
`ifdef ARB_STATS_EN
        , .grant_count0(grant_count0), .grant_count1(grant_count1)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a pending-clear address queue plus the expected write port contents.
    bit          m_ptr;
    logic        m_we, m_src, m_busy;
    logic [3:0]  m_addr;
    logic [15:0] m_data;
    logic [3:0]  clr_q[$];
    int          m_cnt0, m_cnt1;
    bit          e_r0, e_r1;

    function automatic void model_reset();
        m_ptr = 0; m_we = 0; m_src = 0; m_busy = 0; m_addr = 0; m_data = 0;
        clr_q.delete(); m_cnt0 = 0; m_cnt1 = 0;
    endfunction

    function automatic void model_ready();
        e_r0 = !m_busy && !clear_start && req0_valid && (!req1_valid || !m_ptr);
        e_r1 = !m_busy && !clear_start && req1_valid && (!req0_valid || m_ptr);
    endfunction

    function automatic void model_advance();
        if (m_busy) begin
            if (clr_q.size() > 0) begin
                m_addr = clr_q.pop_front(); m_we = 1; m_data = 0; m_src = 0;
            end else begin
                m_we = 0; m_busy = 0;
            end
        end else if (clear_start) begin
            clr_q.delete();
            for (int a = 1; a < 16; a++) clr_q.push_back(4'(a));
            m_we = 1; m_addr = 0; m_data = 0; m_src = 0; m_busy = 1;
        end else if (e_r0) begin
            m_we = 1; m_addr = req0_address; m_data = req0_data; m_src = 0; m_ptr = 1;
            if (m_cnt0 < 65535) m_cnt0++;
        end else if (e_r1) begin
            m_we = 1; m_addr = req1_address; m_data = req1_data; m_src = 1; m_ptr = 0;
            if (m_cnt1 < 65535) m_cnt1++;
        end else begin
            m_we = 0;
        end
    endfunction

    typedef struct {
        logic r0v; logic [3:0] r0a; logic [15:0] r0d;
        logic r1v; logic [3:0] r1a; logic [15:0] r1d;
        logic clr;
        logic x0; logic x1;
        logic xwe; logic [3:0] xa; logic [15:0] xd; logic xs; logic xb;
    } vec_t;

    vec_t vt[9];

    task automatic idle_inputs();
        clear_start = 0;
        req0_valid = 0; req0_address = 0; req0_data = 0;
        req1_valid = 0; req1_address = 0; req1_data = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_asynchronous = 1;
        @(posedge clk); #1;
        reset_asynchronous = 0;
    endtask

    initial begin
        bit found;
        int late;
        bit last0, last1;

        vt[0] = '{1'b1, 4'h3, 16'h00A5, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 16'h00A5, 1'b0, 1'b0};
        vt[1] = '{1'b1, 4'h1, 16'h1001, 1'b1, 4'h2, 16'h2002, 1'b0, 1'b0, 1'b1, 1'b1, 4'h2, 16'h2002, 1'b1, 1'b0};
        vt[2] = '{1'b1, 4'h1, 16'h1001, 1'b1, 4'h4, 16'h2004, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 16'h1001, 1'b0, 1'b0};
        vt[3] = '{1'b1, 4'h5, 16'h1005, 1'b1, 4'h4, 16'h2004, 1'b0, 1'b0, 1'b1, 1'b1, 4'h4, 16'h2004, 1'b1, 1'b0};
        vt[4] = '{1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 16'h2004, 1'b1, 1'b0};
        vt[5] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h9, 16'hBEEF, 1'b0, 1'b0, 1'b1, 1'b1, 4'h9, 16'hBEEF, 1'b1, 1'b0};
        vt[6] = '{1'b1, 4'h7, 16'h1111, 1'b1, 4'h7, 16'h2222, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 16'h1111, 1'b0, 1'b0};
        vt[7] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'h7, 16'h2222, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 16'h2222, 1'b1, 1'b0};
        vt[8] = '{1'b0, 4'h0, 16'h0000, 1'b1, 4'hC, 16'h3333, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b1};

        idle_inputs();
        reset_asynchronous = 1;
        req0_valid = 1; req1_valid = 1;
        #12;
        chk("reset_ready", 64'({req0_ready, req1_ready}), 64'(2'b00));
        chk("reset_outputs", 64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}), 64'(0));
        idle_inputs();
        @(posedge clk); #1;
        reset_asynchronous = 0;

        // Directed vectors, applied back to back from reset (ptr = 0).
        for (int i = 0; i < 9; i++) begin
            req0_valid = vt[i].r0v; req0_address = vt[i].r0a; req0_data = vt[i].r0d;
            req1_valid = vt[i].r1v; req1_address = vt[i].r1a; req1_data = vt[i].r1d;
            clear_start = vt[i].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'({req0_ready, req1_ready}), 64'({vt[i].x0, vt[i].x1}));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_write", i),
                64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}),
                64'({vt[i].xwe, vt[i].xa, vt[i].xd, vt[i].xs, vt[i].xb}));
        end

        // Sweep in progress with req1 held; a second clear_start mid-sweep is ignored.
        for (int k = 1; k <= 16; k++) begin
            clear_start = (k == 8);
            @(negedge clk);
            chk($sformatf("sweep%0d_ready", k), 64'({req0_ready, req1_ready}), 64'(2'b00));
            chk($sformatf("sweep%0d_write", k),
                64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}),
                64'({1'b1, 4'(k - 1), 16'h0000, 1'b0, 1'b1}));
            @(posedge clk); #1;
        end
        clear_start = 0;
        @(negedge clk);
        chk("post_sweep_ready", 64'({req0_ready, req1_ready}), 64'(2'b01));
        chk("post_sweep_idle", 64'({rf_write_enable, busy}), 64'(2'b00));
        @(posedge clk); #1;
        chk("post_sweep_write",
            64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}),
            64'({1'b1, 4'hC, 16'h3333, 1'b1, 1'b0}));
        idle_inputs();

        // Reset during the sweep once address 5 is on the write port.
        clear_start = 1;
        @(posedge clk); #1;
        clear_start = 0;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            if (rf_write_enable && rf_write_address == 4'd5) found = 1;
            else begin @(posedge clk); #1; end
        end
        chk("midsweep_reached_addr5", 64'(found), 64'(1));
        #2;
        reset_asynchronous = 1;
        req0_valid = 1;
        #1;
        chk("midsweep_reset_outputs", 64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}), 64'(0));
        chk("midsweep_reset_ready", 64'({req0_ready, req1_ready}), 64'(2'b00));
        req0_valid = 0;
        @(posedge clk); #1;
        reset_asynchronous = 0;
        late = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rf_write_enable || busy) late++;
        end
        chk("midsweep_no_late_writes", 64'(late), 64'(0));
        @(posedge clk); #1;
        req0_valid = 1; req0_address = 4'h2; req0_data = 16'h5A5A;
        @(negedge clk);
        chk("midsweep_back_in_arb", 64'(req0_ready), 64'(1));
        @(posedge clk); #1;
        chk("midsweep_arb_write", 64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source}),
            64'({1'b1, 4'h2, 16'h5A5A, 1'b0}));
        idle_inputs();

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        last0 = 0; last1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!req0_valid || last0) begin
                req0_valid = ($urandom_range(0, 9) < 6);
                req0_address = 4'($urandom); req0_data = 16'($urandom);
            end
            if (!req1_valid || last1) begin
                req1_valid = ($urandom_range(0, 9) < 6);
                req1_address = 4'($urandom); req1_data = 16'($urandom);
            end
            clear_start = ($urandom_range(0, 99) == 0);
            model_ready();
            @(negedge clk);
            chk("rand_ready", 64'({req0_ready, req1_ready}), 64'({e_r0, e_r1}));
            chk("rand_write", 64'({rf_write_enable, rf_write_address, rf_write_data, rf_write_source, busy}),
                64'({m_we, m_addr, m_data, m_src, m_busy}));
            last0 = e_r0; last1 = e_r1;
            model_advance();
            @(posedge clk); #1;
        end
`ifdef ARB_STATS_EN
        chk("rand_grant_count0", 64'(grant_count0), 64'(m_cnt0));
        chk("rand_grant_count1", 64'(grant_count1), 64'(m_cnt1));
`endif
        idle_inputs();

`ifdef ARB_STATS_EN
        do_reset();
        req0_valid = 1; req0_address = 4'h1; req0_data = 16'h0001;
        repeat (70000) @(posedge clk);
        #1;
        req0_valid = 0;
        chk("sat_grant_count0", 64'(grant_count0), 64'(16'hFFFF));
        chk("sat_grant_count1", 64'(grant_count1), 64'(0));
        clear_start = 1;
        @(posedge clk); #1;
        clear_start = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("sat_after_clear0", 64'(grant_count0), 64'(16'hFFFF));
        chk("sat_after_clear1", 64'(grant_count1), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
